fp_mul_sched: RTL and testbench



---
 rtl/fpu_mul_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/fp_mul_sched.sv | 150 +++++++++++++++
 tb/tb_fp_mul_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_mul_pkg.sv
// Shared types for the fp_mul scheduler: operand layout, rounding modes and FSM states.
package fpu_mul_pkg;

   localparam int LAT_MAX = 15;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RDN = 3'd2,
      RM_RUP = 3'd3,
      RM_RMM = 3'd4
   } rmode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } sched_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin arbiter; prio only breaks ties when both request.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] gnt,
   output logic       idx
);

   always_comb begin
      gnt = 2'b00;
      idx = 1'b0;
      if (req[0] && req[1]) begin
         idx = prio;
         gnt = prio ? 2'b10 : 2'b01;
      end else if (req[1]) begin
         idx = 1'b1;
         gnt = 2'b10;
      end else if (req[0]) begin
         idx = 1'b0;
         gnt = 2'b01;
      end
   end

endmodule

// File: rtl/fp_mul_sched.sv
// Shares one combinational fp_mul between two requesters: round-robin grant, operands held for
// LATENCY cycles, result returned on one tagged valid/ready channel; no new grant until it drains.
module fp_mul_sched
   import fpu_mul_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int RR_INIT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [63:0] req_x,
   input  logic [63:0] req_y,
   input  logic [5:0]  req_rmode,
   output logic [31:0] mul_x,
   output logic [31:0] mul_y,
   output logic [2:0]  mul_rmode,
   input  logic [31:0] mul_z,
   input  logic        mul_ovrf,
   input  logic        mul_udrf,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_z,
   output logic        rsp_ovrf,
   output logic        rsp_udrf,
   output logic        busy
);

   localparam int CW = $clog2(LAT_MAX + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

   sched_state_t  state;
   sched_state_t  state_nxt;
   logic [CW-1:0] cnt;
   logic          prio;
   fp32_t         op_x;
   fp32_t         op_y;
   rmode_t        op_rm;
   logic          op_id;
   fp32_t         res_z;
   logic          res_ovrf;
   logic          res_udrf;
   logic [1:0]    gnt;
   logic          gidx;
   logic          hs;
   logic [1:0]    skipped;

   rr_arb2 u_arb (
      .req  (req_valid),
      .prio (prio),
      .gnt  (gnt),
      .idx  (gidx)
   );

   assign hs = (state == ST_IDLE) && (gnt != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (hs)           state_nxt = ST_BUSY;
         ST_BUSY: if (cnt == '0)    state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready)    state_nxt = ST_IDLE;
         default:                   state_nxt = ST_IDLE;
      endcase
   end

   // req_ready is gated by rst_n so nothing looks accepted while reset is held.
   always_comb begin
      req_ready = 2'b00;
      rsp_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_IDLE: req_ready = gnt & {2{rst_n}};
         ST_BUSY: busy = 1'b1;
         ST_RESP: begin
            busy      = 1'b1;
            rsp_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_x     <= '0;
         op_y     <= '0;
         op_rm    <= RM_RNE;
         op_id    <= 1'b0;
         cnt      <= '0;
         res_z    <= '0;
         res_ovrf <= 1'b0;
         res_udrf <= 1'b0;
         prio     <= RR_INIT[0];
      end else begin
         case (state)
            ST_IDLE: if (hs) begin
               op_x  <= gidx ? req_x[63:32] : req_x[31:0];
               op_y  <= gidx ? req_y[63:32] : req_y[31:0];
               op_rm <= rmode_t'(gidx ? req_rmode[5:3] : req_rmode[2:0]);
               op_id <= gidx;
               cnt   <= CNT_LOAD;
            end
            ST_BUSY: begin
               if (cnt == '0) begin
                  res_z    <= mul_z;
                  res_ovrf <= mul_ovrf;
                  res_udrf <= mul_udrf;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            // Loser of the last grant gets priority for the next tie.
            ST_RESP: if (rsp_ready) prio <= ~op_id;
            default: ;
         endcase
      end
   end

   assign mul_x     = op_x;
   assign mul_y     = op_y;
   assign mul_rmode = op_rm;
   assign rsp_id    = op_id;
   assign rsp_z     = res_z;
   assign rsp_ovrf  = res_ovrf;
   assign rsp_udrf  = res_udrf;

   // Requesters that were valid but lost a grant; they must win the next one if still valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  skipped <= 2'b00;
      else if (hs) skipped <= (skipped | (req_valid & ~gnt)) & ~gnt;
   end

   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
   assert property (@(posedge clk) disable iff (!rst_n) rsp_valid |-> state == ST_RESP);
   assert property (@(posedge clk) disable iff (!rst_n)
      rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_z) && $stable(rsp_id)
                                  && $stable(rsp_ovrf) && $stable(rsp_udrf));
   assert property (@(posedge clk) disable iff (!rst_n)
      state == ST_BUSY && cnt != '0 |=> $stable(mul_x) && $stable(mul_y) && $stable(mul_rmode));
   assert property (@(posedge clk) disable iff (!rst_n)
      hs |-> !(|(skipped & req_valid & ~gnt)));

endmodule

// File: tb/tb_fp_mul_sched.sv
// Directed bench for fp_mul_sched with a stub multiplier; LATENCY 2 main instance plus 1 and 15.
// Latency: checks handshake-to-response counts of LATENCY+1 for each instance.
// Backpressure: exercises rsp_ready held low and verifies no grants while a response is pending.
module tb_fp_mul_sched;

    logic        clk;
    logic        rst_n;
    logic [63:0] rx;
    logic [63:0] ry;
    logic [5:0]  rrm;
    int          checks;
    int          failures;

    logic [1:0]  valid, rdy;
    logic [31:0] mx, my, mz, rz;
    logic [2:0]  mrm;
    logic        movf, mudf, rsp_rdy, rv, rid, rovf, rudf, bsy;

    logic [1:0]  a_valid, a_rdy;
    logic [31:0] a_mx, a_my, a_mz, a_rz;
    logic [2:0]  a_mrm;
    logic        a_movf, a_mudf, a_rsp_rdy, a_rv, a_rid, a_rovf, a_rudf, a_bsy;

    logic [1:0]  b_valid, b_rdy;
    logic [31:0] b_mx, b_my, b_mz, b_rz;
    logic [2:0]  b_mrm;
    logic        b_movf, b_mudf, b_rsp_rdy, b_rv, b_rid, b_rovf, b_rudf, b_bsy;

    function automatic logic [33:0] fmul(input logic [31:0] x, input logic [31:0] y);
        if (x == 32'h40000000 && y == 32'h40400000) return {2'b00, 32'h40C00000};
        if (x == 32'h7F000000 && y == 32'h7F000000) return {2'b10, 32'h7F800000};
        if (x == 32'h00000001 && y == 32'h3F800000) return {2'b01, 32'h00000000};
        return {2'b00, x ^ y};
    endfunction

    assign {movf, mudf, mz}       = fmul(mx, my);
    assign {a_movf, a_mudf, a_mz} = fmul(a_mx, a_my);
    assign {b_movf, b_mudf, b_mz} = fmul(b_mx, b_my);

    fp_mul_sched #(.LATENCY(2), .RR_INIT(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(valid), .req_ready(rdy),
        .req_x(rx), .req_y(ry), .req_rmode(rrm),
        .mul_x(mx), .mul_y(my), .mul_rmode(mrm), .mul_z(mz), .mul_ovrf(movf), .mul_udrf(mudf),
        .rsp_valid(rv), .rsp_ready(rsp_rdy), .rsp_id(rid), .rsp_z(rz),
        .rsp_ovrf(rovf), .rsp_udrf(rudf), .busy(bsy)
    );

    fp_mul_sched #(.LATENCY(1), .RR_INIT(0)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_rdy),
        .req_x(rx), .req_y(ry), .req_rmode(rrm),
        .mul_x(a_mx), .mul_y(a_my), .mul_rmode(a_mrm), .mul_z(a_mz), .mul_ovrf(a_movf), .mul_udrf(a_mudf),
        .rsp_valid(a_rv), .rsp_ready(a_rsp_rdy), .rsp_id(a_rid), .rsp_z(a_rz),
        .rsp_ovrf(a_rovf), .rsp_udrf(a_rudf), .busy(a_bsy)
    );

    fp_mul_sched #(.LATENCY(15), .RR_INIT(0)) dut_l15 (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_rdy),
        .req_x(rx), .req_y(ry), .req_rmode(rrm),
        .mul_x(b_mx), .mul_y(b_my), .mul_rmode(b_mrm), .mul_z(b_mz), .mul_ovrf(b_movf), .mul_udrf(b_mudf),
        .rsp_valid(b_rv), .rsp_ready(b_rsp_rdy), .rsp_id(b_rid), .rsp_z(b_rz),
        .rsp_ovrf(b_rovf), .rsp_udrf(b_rudf), .busy(b_bsy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fail(input string tag);
        failures++;
        $error("FAIL %s", tag);
    endtask

    task automatic issue(input int id, input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
        int lat;
        if (id == 0) begin
            rx[31:0] = x; ry[31:0] = y; rrm[2:0] = rm;
            valid = 2'b01;
        end else begin
            rx[63:32] = x; ry[63:32] = y; rrm[5:3] = rm;
            valid = 2'b10;
        end
        #1;
        checks++; if (rdy !== valid) fail("issue_ready");
        tick();
        valid = 2'b00;
        lat = 1;
        while (!rv && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 3) fail("issue_latency");
    endtask

    initial begin
        int   n;
        logic exp_id;
        checks = 0; failures = 0;
        rst_n = 1'b0; valid = 2'b00; a_valid = 2'b00; b_valid = 2'b00;
        rsp_rdy = 1'b1; a_rsp_rdy = 1'b1; b_rsp_rdy = 1'b1;
        rx = '0; ry = '0; rrm = '0;

        repeat (2) @(posedge clk);
        #1; valid = 2'b11; #1;
        checks++; if (rdy !== 2'b00) fail("rst_ready");
        checks++; if (rv !== 1'b0) fail("rst_rsp_valid");
        checks++; if (bsy !== 1'b0) fail("rst_busy");
        checks++; if (rz !== 32'h0) fail("rst_rsp_z");
        checks++; if (rid !== 1'b0) fail("rst_rsp_id");
        checks++; if ({rovf, rudf} !== 2'b00) fail("rst_flags");
        checks++; if ({mx, my, mrm} !== 67'h0) fail("rst_mul");

        tick();
        rst_n = 1'b1; valid = 2'b00;
        rx[31:0] = 32'h40000000; ry[31:0] = 32'h40400000; rrm[2:0] = 3'd0;
        valid = 2'b01; #1;
        checks++; if (rdy !== 2'b01) fail("t1_ready");
        tick();
        valid = 2'b00; rx = '0; ry = '0;
        checks++; if (bsy !== 1'b1) fail("t1_busy");
        checks++; if (mx !== 32'h40000000) fail("t1_mul_x");
        checks++; if (my !== 32'h40400000) fail("t1_mul_y");
        checks++; if (rv !== 1'b0) fail("t1_no_rsp1");
        tick();
        checks++; if (rv !== 1'b0) fail("t1_no_rsp2");
        checks++; if (mx !== 32'h40000000) fail("t1_hold_x");
        tick();
        checks++; if (rv !== 1'b1) fail("t1_rsp_valid");
        checks++; if (rid !== 1'b0) fail("t1_rsp_id");
        checks++; if (rz !== 32'h40C00000) fail("t1_rsp_z");
        checks++; if ({rovf, rudf} !== 2'b00) fail("t1_flags");
        tick();
        checks++; if (bsy !== 1'b0) fail("t1_idle_busy");
        checks++; if (rv !== 1'b0) fail("t1_idle_rsp");

        issue(1, 32'h00000001, 32'h3F800000, 3'd1);
        checks++; if (rid !== 1'b1) fail("sub_id");
        checks++; if (rz[30:0] !== 31'd0) fail("sub_z_mag");
        checks++; if (rudf !== 1'b1) fail("sub_udrf");
        checks++; if (mrm !== 3'd1) fail("sub_rmode");
        tick();
        issue(0, 32'h7F000000, 32'h7F000000, 3'd0);
        checks++; if (rid !== 1'b0) fail("ovf_id");
        checks++; if (rz !== 32'h7F800000) fail("ovf_z");
        checks++; if (rovf !== 1'b1) fail("ovf_ovrf");
        checks++; if (rudf !== 1'b0) fail("ovf_udrf");
        tick();

        rsp_rdy = 1'b0;
        issue(1, 32'hAAAA0000, 32'h00005555, 3'd4);
        valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (rv !== 1'b1) fail("bp_valid");
            checks++; if (rz !== 32'hAAAA5555) fail("bp_z");
            checks++; if (rid !== 1'b1) fail("bp_id");
            checks++; if (rdy !== 2'b00) fail("bp_ready");
            tick();
        end
        rsp_rdy = 1'b1; #1;
        checks++; if (rdy !== 2'b00) fail("bp_hs_ready");
        tick();
        checks++; if (rv !== 1'b0) fail("bp_released");
        checks++; if (rdy !== 2'b01) fail("bp_next_grant");
        valid = 2'b00;

        issue(0, 32'h11110000, 32'h00002222, 3'd0);
        checks++; if (rz !== 32'h11112222) fail("wd_z");
        tick();
        valid = 2'b11; #1;
        checks++; if (rdy !== 2'b10) fail("prio_after_rsp");
        tick();
        tick();
        checks++; if (bsy !== 1'b1) fail("mid_busy");
        checks++; if (mx !== 32'hAAAA0000) fail("mid_mul_x");
        rst_n = 1'b0; #1;
        checks++; if (rdy !== 2'b00) fail("arst_ready");
        checks++; if (bsy !== 1'b0) fail("arst_busy");
        checks++; if ({rv, rid, rovf, rudf} !== 4'h0) fail("arst_rsp");
        checks++; if (rz !== 32'h0) fail("arst_z");
        checks++; if ({mx, my, mrm} !== 67'h0) fail("arst_mul");
        tick();
        valid = 2'b00; rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (rv !== 1'b0) fail("arst_no_rsp");
        end

        valid = 2'b11;
        exp_id = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n = 0;
            while (rdy == 2'b00 && n < 20) begin
                tick();
                n++;
            end
            checks++; if (n !== 0) fail("rr_no_gap");
            checks++; if (rdy !== (exp_id ? 2'b10 : 2'b01)) fail("rr_grant");
            tick();
            n = 1;
            while (!rv && n < 40) begin
                checks++; if ($onehot0(rdy) !== 1'b1) fail("rr_onehot0");
                tick();
                n++;
            end
            checks++; if (n !== 3) fail("rr_latency");
            checks++; if (rid !== exp_id) fail("rr_id");
            checks++; if (rz !== (exp_id ? 32'hAAAA5555 : 32'h11112222)) fail("rr_z");
            tick();
            exp_id = ~exp_id;
        end
        valid = 2'b00;

        rx[31:0] = 32'h40000000; ry[31:0] = 32'h40400000; rrm[2:0] = 3'd0;
        a_valid = 2'b01; #1;
        checks++; if (a_rdy !== 2'b01) fail("l1_ready");
        tick();
        a_valid = 2'b00; rx[31:0] = 32'h0;
        n = 1;
        while (!a_rv && n < 40) begin
            checks++; if (a_mx !== 32'h40000000) fail("l1_hold");
            tick();
            n++;
        end
        checks++; if (n !== 2) fail("l1_latency");
        checks++; if (a_rz !== 32'h40C00000) fail("l1_z");
        checks++; if ({a_rid, a_rovf, a_rudf, a_mrm} !== 6'h0) fail("l1_id_flags");
        checks++; if (a_bsy !== 1'b1) fail("l1_busy");
        tick();

        rx[31:0] = 32'h40000000;
        b_valid = 2'b01; #1;
        checks++; if (b_rdy !== 2'b01) fail("l15_ready");
        tick();
        b_valid = 2'b00; rx[31:0] = 32'h0; ry[31:0] = 32'h0;
        n = 1;
        while (!b_rv && n < 40) begin
            checks++; if ({b_mx, b_my} !== {32'h40000000, 32'h40400000}) fail("l15_hold");
            tick();
            n++;
        end
        checks++; if (n !== 16) fail("l15_latency");
        checks++; if (b_rz !== 32'h40C00000) fail("l15_z");
        checks++; if ({b_rid, b_rovf, b_rudf, b_mrm} !== 6'h0) fail("l15_id_flags");
        checks++; if (b_bsy !== 1'b1) fail("l15_busy");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
